// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
package mem_arbiter_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_LINE_W = 256;

   // Bit positions inside the one-hot grant vector produced by rr_arb2.
   localparam int GNT_I = 0;
   localparam int GNT_D = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      SIDE_I = 1'b0,
      SIDE_D = 1'b1
   } arb_side_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick. On a tie the side that did not win
// last time is granted; a lone requester is always granted. Output is one-hot
// (bit GNT_I / bit GNT_D) or all-zero when nobody requests.
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic       i_req_i,
   input  logic       i_req_d,
   input  arb_side_t  i_last_grant,
   output logic [1:0] o_grant
);

   // Round-robin selection between the two requesters.
   always_comb begin
      o_grant = 2'b00;
      if (i_req_i && i_req_d) begin
         if (i_last_grant == SIDE_D) begin
            o_grant[GNT_I] = 1'b1;
         end else begin
            o_grant[GNT_D] = 1'b1;
         end
      end else if (i_req_i) begin
         o_grant[GNT_I] = 1'b1;
      end else if (i_req_d) begin
         o_grant[GNT_D] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one cacheline memory port between the I-cache and D-cache.
// Whole-line transactions are granted one at a time from IDLE; the granted
// address/op/writeback data are latched so memory sees stable values until
// mem_resp. All mem_* outputs come from registers or the state decode, so no
// requester input reaches memory combinationally. o_state exposes the FSM.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int LINE_W = ARB_LINE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output arb_state_t        o_state
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   arb_side_t         r_last_grant;
   logic              r_op_write;
   logic [ADDR_W-1:0] r_address;
   logic [LINE_W-1:0] r_wdata;
   logic [1:0]        w_grant;
   logic              w_req_d;

   // A D-side read and writeback held together still count as one request;
   // the write wins the grant and the read is picked up on a later grant.
   assign w_req_d = d_read | d_write;

   rr_arb2 u_rr_arb2 (
      .i_req_i      (i_read),
      .i_req_d      (w_req_d),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: grant from IDLE, return to IDLE on the memory response.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant[GNT_I]) begin
               w_state_nxt = SERVE_I;
            end else if (w_grant[GNT_D]) begin
               w_state_nxt = SERVE_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_resp) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Latch the granted transaction and remember the winner on the grant edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_grant <= SIDE_D;
         r_op_write   <= 1'b0;
         r_address    <= '0;
         r_wdata      <= '0;
      end else if (r_state == IDLE) begin
         if (w_grant[GNT_I]) begin
            r_last_grant <= SIDE_I;
            r_op_write   <= 1'b0;
            r_address    <= i_address;
         end else if (w_grant[GNT_D]) begin
            r_last_grant <= SIDE_D;
            r_op_write   <= d_write;
            r_address    <= d_address;
            r_wdata      <= d_wdata;
         end
      end
   end

   // Decode memory strobes and requester responses from the state.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      i_resp    = 1'b0;
      d_resp    = 1'b0;
      case (r_state)
         SERVE_I: begin
            mem_read = 1'b1;
            i_resp   = mem_resp;
         end
         SERVE_D: begin
            mem_read  = ~r_op_write;
            mem_write = r_op_write;
            d_resp    = mem_resp;
         end
         default: ;
      endcase
   end

   assign mem_address = r_address;
   assign mem_wdata   = r_wdata;
   assign i_rdata     = mem_rdata;
   assign d_rdata     = mem_rdata;
   assign o_state     = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized phase.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;
  arb_state_t    dbg_state;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .o_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // One outstanding transaction at most; a new one may start only on an edge
  // where none is outstanding. On a tie the side whose turn it is wins.
  bit            m_busy = 1'b0;
  bit            m_side_d = 1'b0;
  bit            m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  bit            m_turn_i = 1'b1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_side_d = 1'b0; m_write = 1'b0;
      m_addr = '0; m_wdata = '0; m_turn_i = 1'b1;
    end else if (m_busy) begin
      if (mem_resp) m_busy = 1'b0;
    end else begin
      if (i_read && (!(d_read || d_write) || m_turn_i)) begin
        m_busy = 1'b1; m_side_d = 1'b0; m_write = 1'b0;
        m_addr = i_address; m_turn_i = 1'b0;
      end else if (d_read || d_write) begin
        m_busy = 1'b1; m_side_d = 1'b1; m_write = d_write;
        m_addr = d_address; m_wdata = d_wdata; m_turn_i = 1'b1;
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("mem_read", 256'(mem_read), 256'(m_busy && !m_write));
      check("mem_write", 256'(mem_write), 256'(m_busy && m_write));
      check("mem_address", 256'(mem_address), 256'(m_addr));
      check("mem_wdata", mem_wdata, m_wdata);
      check("i_resp", 256'(i_resp), 256'(m_busy && !m_side_d && mem_resp));
      check("d_resp", 256'(d_resp), 256'(m_busy && m_side_d && mem_resp));
      check("i_rdata", i_rdata, mem_rdata);
      check("d_rdata", d_rdata, mem_rdata);
      check("state", 256'(dbg_state),
            256'(!m_busy ? IDLE : (m_side_d ? SERVE_D : SERVE_I)));
    end
  end

  // ---------------- driver state ----------------
  bit            rand_en = 1'b0;
  bit            hold = 1'b0;
  bit            force_resp = 1'b0;
  int            lat = 0;
  int            cnt = 0;
  bit            seen_i = 1'b0;
  bit            seen_dw = 1'b0;
  bit            seen_dr = 1'b0;
  logic [LW-1:0] line_a;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic rand_req();
    if (!i_read) begin
      if ($urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_address = $urandom() & 32'hffff_ffe0;
      end
    end else if ($urandom_range(0, 49) == 0) begin
      i_read = 1'b0;
    end
    if (!d_read && !d_write) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0: d_read = 1'b1;
          1: d_write = 1'b1;
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_address = $urandom() & 32'hffff_ffe0;
        d_wdata = rand_line();
      end
    end
    if ($urandom_range(0, 7) == 0) d_address = $urandom() & 32'hffff_ffe0;
    if ($urandom_range(0, 7) == 0) d_wdata = rand_line();
  endtask

  // One clock: requester drops, memory responder, optional random traffic,
  // then sample the responses at the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!hold) begin
      if (seen_i) i_read = 1'b0;
      if (seen_dw) d_write = 1'b0;
      if (seen_dr) d_read = 1'b0;
    end
    if (!(mem_read || mem_write)) begin
      cnt = 0;
      mem_resp = 1'b0;
      if (force_resp || (rand_en && $urandom_range(0, 15) == 0)) mem_resp = 1'b1;
      force_resp = 1'b0;
    end else begin
      if (cnt == 0 && rand_en) lat = $urandom_range(0, 4);
      mem_resp = (cnt == lat);
      if (mem_resp) mem_rdata = rand_en ? rand_line() : line_a;
      cnt++;
    end
    if (rand_en) rand_req();
    @(negedge clk);
    seen_i = i_resp;
    seen_dw = d_resp && mem_write;
    seen_dr = d_resp && mem_read;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    mem_resp = 1'b0; cnt = 0; hold = 1'b0;
    seen_i = 1'b0; seen_dw = 1'b0; seen_dr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  logic [0:0]    exp_q[$];
  logic [0:0]    got_q[$];
  logic [LW-1:0] line_w, line_x, line_y, cap_wdata;
  logic [AW-1:0] cap_addr;
  int            str_cnt, first_str, last_str, resp_cnt, resp_cyc, dresp_cnt;
  int            i_resp_cyc, d_str_cyc, d_done, n_got;
  int            n_i_done, n_d_done;
  bit            hit;
  logic [LW-1:0] cap_rdata;

  initial begin
    line_a = rand_line();
    line_w = rand_line();
    line_x = rand_line();
    line_y = rand_line();

    // Reset only: nothing moves, a stray mem_resp in IDLE is ignored.
    apply_reset();
    chk_en = 1'b1;
    check("reset_mem_read", 256'(mem_read), 256'(0));
    check("reset_mem_address", 256'(mem_address), 256'(0));
    check("reset_state", 256'(dbg_state), 256'(IDLE));
    str_cnt = 0; resp_cnt = 0;
    for (int r = 1; r <= 20; r++) begin
      if (r == 5) force_resp = 1'b1;
      cycle();
      if (mem_read || mem_write) str_cnt++;
      if (i_resp || d_resp) resp_cnt++;
    end
    check("idle_strobes", 256'(str_cnt), 256'(0));
    check("idle_resps", 256'(resp_cnt), 256'(0));

    // Single I read at 0x60, memory answers 3 cycles after the strobe.
    apply_reset();
    i_address = 32'h0000_0060; i_read = 1'b1; lat = 3;
    str_cnt = 0; first_str = -1; last_str = -1; resp_cnt = 0; resp_cyc = -1; dresp_cnt = 0;
    cap_rdata = '0;
    for (int r = 1; r <= 8; r++) begin
      cycle();
      if (mem_read) begin
        str_cnt++;
        if (first_str < 0) first_str = r;
        last_str = r;
        check("iread_addr", 256'(mem_address), 256'(32'h60));
      end
      if (i_resp) begin resp_cnt++; resp_cyc = r; cap_rdata = i_rdata; end
      if (d_resp) dresp_cnt++;
    end
    check("iread_first_strobe", 256'(first_str), 256'(1));
    check("iread_last_strobe", 256'(last_str), 256'(4));
    check("iread_strobe_cycles", 256'(str_cnt), 256'(4));
    check("iread_resp_count", 256'(resp_cnt), 256'(1));
    check("iread_resp_cycle", 256'(resp_cyc), 256'(4));
    check("iread_rdata", cap_rdata, line_a);
    check("iread_no_dresp", 256'(dresp_cnt), 256'(0));

    // Simultaneous I read and D write from reset: I first, D strobe 2 after.
    apply_reset();
    i_address = 32'h80; i_read = 1'b1;
    d_address = 32'h100; d_wdata = line_w; d_write = 1'b1; lat = 2;
    i_resp_cyc = -1; d_str_cyc = -1; d_done = -1; cap_wdata = '0; cap_addr = '0;
    for (int r = 1; r <= 20; r++) begin
      cycle();
      if (i_resp && i_resp_cyc < 0) i_resp_cyc = r;
      if (mem_write && d_str_cyc < 0) begin
        d_str_cyc = r; cap_wdata = mem_wdata; cap_addr = mem_address;
      end
      if (d_resp && d_done < 0) d_done = r;
    end
    check("tie_i_resp_cycle", 256'(i_resp_cyc), 256'(3));
    check("tie_d_strobe_cycle", 256'(d_str_cyc), 256'(5));
    check("tie_spacing", 256'(d_str_cyc - i_resp_cyc), 256'(2));
    check("tie_d_wdata", cap_wdata, line_w);
    check("tie_d_addr", 256'(cap_addr), 256'(32'h100));
    check("tie_d_done", 256'(d_done), 256'(7));

    // Both sides continuously requesting: strict alternation I,D,I,D,I,D.
    apply_reset();
    hold = 1'b1; lat = 1;
    i_address = 32'h40; i_read = 1'b1;
    d_address = 32'h140; d_read = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(1'(k % 2));
    got_q.delete();
    for (int r = 0; r < 60 && got_q.size() < 6; r++) begin
      cycle();
      if (i_resp) got_q.push_back(1'b0);
      if (d_resp) got_q.push_back(1'b1);
    end
    n_got = got_q.size();
    check("rr_grant_count", 256'(n_got), 256'(6));
    while (exp_q.size() > 0) begin
      logic [0:0] e, g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
      check("rr_grant_order", 256'(g), 256'(e));
    end
    hold = 1'b0; i_read = 1'b0; d_read = 1'b0;
    repeat (6) cycle();

    // D address/data change while served: memory keeps the latched values.
    apply_reset();
    d_address = 32'h200; d_wdata = line_x; d_read = 1'b1; lat = 4;
    cycle();
    check("hold_strobe", 256'(mem_read), 256'(1));
    d_address = 32'h300; d_wdata = line_y;
    hit = 1'b0;
    for (int r = 2; r <= 8; r++) begin
      cycle();
      if (d_resp) begin
        hit = 1'b1;
        check("hold_addr", 256'(mem_address), 256'(32'h200));
        check("hold_wdata", mem_wdata, line_x);
      end
    end
    check("hold_resp_seen", 256'(hit), 256'(1));

    // Asynchronous reset in the middle of a D read.
    apply_reset();
    d_address = 32'h400; d_read = 1'b1; lat = 10;
    cycle(); cycle(); cycle();
    check("pre_rst_strobe", 256'(mem_read), 256'(1));
    #2 rst = 1'b0;
    #1;
    check("arst_mem_read", 256'(mem_read), 256'(0));
    check("arst_mem_write", 256'(mem_write), 256'(0));
    check("arst_d_resp", 256'(d_resp), 256'(0));
    check("arst_mem_address", 256'(mem_address), 256'(0));
    check("arst_state", 256'(dbg_state), 256'(IDLE));
    cnt = 0; mem_resp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    cycle();
    check("rearm_strobe", 256'(mem_read), 256'(1));
    check("rearm_addr", 256'(mem_address), 256'(32'h400));
    hit = 1'b0;
    for (int r = 0; r < 20 && !hit; r++) begin
      cycle();
      if (d_resp) hit = 1'b1;
    end
    check("rearm_resp_seen", 256'(hit), 256'(1));

    // Randomized traffic against the model.
    apply_reset();
    rand_en = 1'b1;
    n_i_done = 0; n_d_done = 0;
    for (int r = 0; r < 3000; r++) begin
      cycle();
      if (i_resp) n_i_done++;
      if (d_resp) n_d_done++;
    end
    rand_en = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (10) cycle();
    check("rand_i_served", 256'(n_i_done > 20), 256'(1));
    check("rand_d_served", 256'(n_d_done > 20), 256'(1));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single physical-memory (cacheline adaptor) port between the instruction cache and the data cache. It sits below both caches, beside the pipeline's fetch and EX/MEM-to-MEM path. It grants whole-line transactions one at a time, using round-robin on simultaneous requests. It holds the granted requester's address and data stable toward memory until `mem_resp`.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `LINE_W`, 256, cache line width.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `i_read`  in  1  I-cache line read request; held until `i_resp`.
- `i_address`  in  ADDR_W  I-cache line address.
- `i_rdata`  out  LINE_W  line data to I-cache.
- `i_resp`  out  1  I-side transaction complete.
- `d_read`  in  1  D-cache line read request; held until `d_resp`.
- `d_write`  in  1  D-cache line writeback request; held until `d_resp`.
- `d_address`  in  ADDR_W  D-cache line address.
- `d_wdata`  in  LINE_W  writeback data.
- `d_rdata`  out  LINE_W  line data to D-cache.
- `d_resp`  out  1  D-side transaction complete.
- `mem_read`  out  1  read to memory.
- `mem_write`  out  1  write to memory.
- `mem_address`  out  ADDR_W  latched address.
- `mem_wdata`  out  LINE_W  latched writeback data.
- `mem_rdata`  in  LINE_W  memory read data.
- `mem_resp`  in  1  memory done.

## Operation
- FSM states:
  - `IDLE`: sample requests. No pending request: stay.
  - Exactly one side pending: grant that side.
  - Both pending: grant the side not recorded in `last_grant`.
  - `SERVE_I`: `mem_read`=1. On `mem_resp`: `i_resp`=1 for that cycle, then go to `IDLE`.
  - `SERVE_D`: `mem_read` or `mem_write`=1 per the latched op. On `mem_resp`: `d_resp`=1 for that cycle, then go to `IDLE`.
- On grant (IDLE→SERVE_x edge):
  - Latch address, op and (D only) `d_wdata` into `mem_address`/`mem_wdata`.
  - Set `last_grant` to the granted side.
- `d_read` and `d_write` both high: write takes precedence. Both stay held, so the read is served as a separate later grant.
- `i_rdata` = `d_rdata` = `mem_rdata` (combinational passthrough). Data is only meaningful when the matching `*_resp` is high.
- `mem_resp` while in `IDLE` is ignored.
- Requests that drop before their grant are not served.
- Requests that change while in SERVE_x do not affect the in-flight transaction.
- Reset values:
  - State `IDLE`; `last_grant`=D, so I wins the first tie.
  - `mem_read`, `mem_write`, `i_resp`, `d_resp` = 0.
  - `mem_address`, `mem_wdata` = 0.

## Timing
- Request seen in `IDLE` at cycle 0 → SERVE_x and `mem_read`/`mem_write` high at cycle 1. This is one cycle of arbitration latency.
- `mem_read`/`mem_write` stay high until and including the `mem_resp` cycle N, and drop at N+1.
- `*_resp` is combinational from `mem_resp` and the state, so it is high in cycle N only.
- State is `IDLE` at N+1. A pending request is then granted, with memory strobes at N+2. Minimum back-to-back spacing: 2 cycles between a `mem_resp` and the next strobe.
- `mem_resp` in the same cycle the strobe first rises (a 1-cycle memory) is legal and completes normally.
- Asynchronous `rst` assertion mid-transaction:
  - All outputs go to their reset values immediately.
  - The in-flight transaction is abandoned with no `*_resp`.
  - Requesters re-issue after reset.
- No combinational path from requester inputs to `mem_*` outputs; all `mem_*` outputs are registered or state-decoded.

## Structure
- Shared package (alongside `rv32i_types`):
  - `arb_state_t` enum {IDLE, SERVE_I, SERVE_D}.
  - `arb_side_t` enum {SIDE_I, SIDE_D}.
  - Line-width constant.
- One natural sub-module: `rr_arb2`, a combinational 2-way round-robin pick from (`req_i`, `req_d`, `last_grant`), producing a one-hot grant. Reused later for L2 arbitration.

## Test plan
- Reset only, no requests → all outputs 0, no strobes for 20 cycles; `mem_resp` pulse in IDLE ignored.
- `i_read`, `i_address`=0x0000_0060, memory responds 3 cycles after the strobe with `mem_rdata`=line A:
  - `mem_read` high cycles 1–4 with `mem_address`=0x60.
  - `i_resp`=1 only in cycle 4 with `i_rdata`=A.
  - `d_resp` stays 0.
- `i_read` and `d_write` rise in the same cycle from reset:
  - I is served first, then D (write, `mem_wdata`=`d_wdata`).
  - D's strobe rises exactly 2 cycles after I's `mem_resp`.
- Both sides request continuously for 6 transactions → grants alternate I, D, I, D, I, D; neither side is starved.
- `d_address`/`d_wdata` change during SERVE_D → `mem_address`/`mem_wdata` keep the values latched at grant until `mem_resp`.
- `rst` low 2 cycles into SERVE_D (before `mem_resp`):
  - Strobes and resps drop asynchronously.
  - After release, the held `d_read` is re-granted from IDLE with the first strobe one cycle later.
